multi_sig_change: RTL and testbench

MULTI_SIG_CHANGE -- requirements
Module: multi_sig_change

---
 rtl/multi_sig_change.sv | 126 ++++++++++++
 tb/tb_multi_sig_change.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multi_sig_change.sv
// rtl/multi_sig_change.sv - per-channel synchronised rise/fall/toggle detector with sticky flags and saturating event count
// Optional glitch filter compiled in with macro SIG_CHANGE_FILTER_EN.
module multi_sig_change #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int FILT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] mask,
  input  logic             clr,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] toggle,
  output logic [WIDTH-1:0] rise_sticky,
  output logic [WIDTH-1:0] fall_sticky,
  output logic             any_event,
  output logic [CNT_W-1:0] evt_cnt
);
  localparam int PW  = $clog2(SYNC_STAGES + 1);
  localparam int PCW = $clog2(WIDTH + 1);
  localparam int SW  = CNT_W + PCW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILT_CYCLES < 1) begin : g_chk_filt
    $error("FILT_CYCLES must be at least 1");
  end

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_q;
  logic [PW-1:0]    r_prime_cnt;
  logic             w_primed;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_s_next;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_evt;
  logic [PCW-1:0]   w_pop;
  logic [SW-1:0]    w_sum;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_s_next = r_sync[SYNC_STAGES-2];
  assign w_primed = (r_prime_cnt == PW'(SYNC_STAGES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

`ifdef SIG_CHANGE_FILTER_EN
  localparam int FW = $clog2(FILT_CYCLES + 1);
  logic [FW-1:0] r_filt      [WIDTH];
  logic [FW-1:0] w_filt_next [WIDTH];

  // A level is accepted on the FILT_CYCLES-th consecutive mismatching edge.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_filt_next[i] = '0;
      if (w_primed && (w_s[i] != r_q[i])) begin
        if (r_filt[i] == FW'(FILT_CYCLES - 1)) w_accept[i] = 1'b1;
        else                                   w_filt_next[i] = r_filt[i] + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) r_filt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) r_filt[i] <= w_filt_next[i];
    end
  end
`else
  assign w_accept = w_s ^ r_q;
`endif

  assign w_evt = w_primed ? (w_accept & ~mask) : '0;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) w_pop = w_pop + PCW'(w_evt[i]);
    w_cnt_base = clr ? '0 : evt_cnt;
    w_sum      = SW'(w_cnt_base) + SW'(w_pop);
    w_cnt_next = (w_sum > SW'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];
  end

  // While priming, q preloads the level s is about to take so reset zeros never look like events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q         <= '0;
      r_prime_cnt <= '0;
      rise        <= '0;
      fall        <= '0;
      toggle      <= '0;
      any_event   <= 1'b0;
      rise_sticky <= '0;
      fall_sticky <= '0;
      evt_cnt     <= '0;
    end else begin
      if (!w_primed) begin
        r_q         <= w_s_next;
        r_prime_cnt <= r_prime_cnt + PW'(1);
      end else begin
        r_q <= r_q ^ w_accept;
      end
      rise        <= w_evt & w_s;
      fall        <= w_evt & ~w_s;
      toggle      <= w_evt;
      any_event   <= |w_evt;
      rise_sticky <= (clr ? '0 : rise_sticky) | (w_evt & w_s);
      fall_sticky <= (clr ? '0 : fall_sticky) | (w_evt & ~w_s);
      evt_cnt     <= w_cnt_next;
    end
  end
endmodule

// File: tb/tb_multi_sig_change.sv
// tb/tb_multi_sig_change.sv - directed table-driven bench for multi_sig_change (WIDTH=4, SYNC_STAGES=2, CNT_W=4)
module tb_multi_sig_change;
  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int CW   = 4;
  localparam int FC   = 3;
`ifdef SIG_CHANGE_FILTER_EN
  localparam int LAT = SYNC + FC - 1;
`else
  localparam int LAT = SYNC;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  d     = '0;
  logic [W-1:0]  mask  = '0;
  logic          clr   = 1'b0;
  logic [W-1:0]  rise, fall, toggle, rise_sticky, fall_sticky;
  logic          any_event;
  logic [CW-1:0] evt_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0]  d;
    logic [W-1:0]  mask;
    logic          clr;
    logic [W-1:0]  rise;
    logic [W-1:0]  fall;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rs;
    logic [W-1:0]  fs;
  } vec_t;

  vec_t vecs [16];

  multi_sig_change #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .CNT_W(CW), .FILT_CYCLES(FC)
  ) dut (
    .clk(clk), .reset(reset), .d(d), .mask(mask), .clr(clr),
    .rise(rise), .fall(fall), .toggle(toggle),
    .rise_sticky(rise_sticky), .fall_sticky(fall_sticky),
    .any_event(any_event), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rise"}, 32'(rise), 0);
    check({name, "_fall"}, 32'(fall), 0);
    check({name, "_toggle"}, 32'(toggle), 0);
    check({name, "_any"}, 32'(any_event), 0);
    check({name, "_rs"}, 32'(rise_sticky), 0);
    check({name, "_fs"}, 32'(fall_sticky), 0);
    check({name, "_cnt"}, 32'(evt_cnt), 0);
  endtask

  initial begin
    logic [CW-1:0] prev_cnt;

    vecs[0]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'd1,  4'b0001, 4'b0000};
    vecs[1]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'd2,  4'b0001, 4'b0001};
    vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'd0,  4'b0000, 4'b0000};
    vecs[3]  = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 4'd4,  4'b1111, 4'b0000};
    vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 4'd8,  4'b1111, 4'b1111};
    vecs[5]  = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 4'd12, 4'b1111, 4'b1111};
    vecs[6]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 4'd15, 4'b1111, 4'b1111};
    vecs[7]  = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 4'd15, 4'b1111, 4'b1111};
    vecs[8]  = '{4'b1011, 4'b0000, 1'b1, 4'b0000, 4'b0100, 4'd1,  4'b0000, 4'b0100};
    vecs[9]  = '{4'b1011, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'd1,  4'b0000, 4'b0100};
    vecs[10] = '{4'b1001, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'd1,  4'b0000, 4'b0100};
    vecs[11] = '{4'b1011, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'd1,  4'b0000, 4'b0100};
    vecs[12] = '{4'b1001, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'd1,  4'b0000, 4'b0100};
    vecs[13] = '{4'b1001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'd1,  4'b0000, 4'b0100};
    vecs[14] = '{4'b1011, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'd2,  4'b0010, 4'b0100};
    vecs[15] = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b1011, 4'd6,  4'b0110, 4'b1111};

    // Levels held high through reset release must never report.
    reset = 1'b0;
    d     = 4'b1111;
    #1;
    check_all_zero("reset_state");
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("prime_toggle", 32'(toggle), 0);
      check("prime_cnt", 32'(evt_cnt), 0);
    end
    check("prime_q", 32'(dut.r_q), 32'hF);

    reset = 1'b0;
    d     = 4'b0000;
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < SYNC + 3; i++) begin
      tick(1);
      check("prime0_toggle", 32'(toggle), 0);
    end

    prev_cnt = '0;
    foreach (vecs[i]) begin
      d    = vecs[i].d;
      mask = vecs[i].mask;
      tick(1);
      tick(LAT - 1);
      check($sformatf("v%0d_pre_toggle", i), 32'(toggle), 0);
      check($sformatf("v%0d_pre_cnt", i), 32'(evt_cnt), 32'(prev_cnt));
      clr = vecs[i].clr;
      tick(1);
      clr = 1'b0;
      check($sformatf("v%0d_rise", i), 32'(rise), 32'(vecs[i].rise));
      check($sformatf("v%0d_fall", i), 32'(fall), 32'(vecs[i].fall));
      check($sformatf("v%0d_toggle", i), 32'(toggle), 32'(vecs[i].rise | vecs[i].fall));
      check($sformatf("v%0d_any", i), 32'(any_event), 32'(|(vecs[i].rise | vecs[i].fall)));
      check($sformatf("v%0d_cnt", i), 32'(evt_cnt), 32'(vecs[i].cnt));
      check($sformatf("v%0d_rs", i), 32'(rise_sticky), 32'(vecs[i].rs));
      check($sformatf("v%0d_fs", i), 32'(fall_sticky), 32'(vecs[i].fs));
      tick(1);
      check($sformatf("v%0d_post_toggle", i), 32'(toggle), 0);
      prev_cnt = vecs[i].cnt;
    end

`ifdef SIG_CHANGE_FILTER_EN
    d = 4'b1100;
    tick(2);
    d = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("glitch2_toggle", 32'(toggle), 0);
    end
    check("glitch2_cnt", 32'(evt_cnt), 6);

    d = 4'b1100;
    tick(3);
    d = 4'b0100;
    tick(1);
    check("filt3_pre_toggle", 32'(toggle), 0);
    tick(1);
    check("filt3_rise", 32'(rise), 32'h8);
    check("filt3_cnt", 32'(evt_cnt), 7);
    tick(1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("filt_midreset");
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      tick(1);
      check("filt_after_reset_toggle", 32'(toggle), 0);
    end
`endif

    // In-flight change discarded by a mid-operation reset.
    d = 4'b1111;
    tick(LAT + 2);
    d = 4'b0000;
    tick(1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("midreset");
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      tick(1);
      check("after_reset_toggle", 32'(toggle), 0);
      check("after_reset_cnt", 32'(evt_cnt), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
